// File: rtl/switch_mcu_alu_shift.sv
// Shift execution unit: reads rs1/rs2 through the register-file ports, shifts, writes rd.
// Optional SWITCH_MCU_ALU_SHIFT_SERIAL_EN replaces the barrel shifter with a one-bit-per-cycle shifter.
module switch_mcu_alu_shift #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_en,
  input  logic               in_start,
  input  logic [1:0]         in_op,
  input  logic               in_use_imm,
  input  logic [11:0]        in_imm_type_i,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [4:0]         in_rd,
  input  logic [XLEN-1:0]    in_rdata_1,
  input  logic [XLEN-1:0]    in_rdata_2,
  output logic               out_ren_1,
  output logic               out_ren_2,
  output logic [4:0]         out_raddr_1,
  output logic [4:0]         out_raddr_2,
  output logic               out_wen,
  output logic [4:0]         out_waddr,
  output logic [XLEN-1:0]    out_wdata,
  output logic               out_busy,
  output logic               out_done
);

  localparam int unsigned IMM_W = 12;
  localparam int unsigned REG_W = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SHIFT,
    S_WRITE
  } state_t;

  state_t state_q, state_n;

  logic [1:0]         op_q;
  logic               use_imm_q;
  logic [SHAMT_W-1:0] imm_q;
  logic [REG_W-1:0]   rd_q;
  logic [XLEN-1:0]    operand_q;
  logic [SHAMT_W-1:0] shamt_q;

  logic               ren_1_n, ren_2_n, wen_n, busy_n, done_n;
  logic [REG_W-1:0]   raddr_1_n, raddr_2_n, waddr_n;
  logic [XLEN-1:0]    wdata_n;

  logic [SHAMT_W-1:0] shamt_sel_c;
  logic [XLEN-1:0]    result_c;
  logic               shift_last_c;
  logic               launch_c;

  // Only the low SHAMT_W bits of the immediate and of rs2 data select the shift.
  logic unused_bits;
  assign unused_bits = ^{in_imm_type_i[IMM_W-1:SHAMT_W], in_rdata_2[XLEN-1:SHAMT_W]};

  assign launch_c    = (state_q == S_IDLE) && in_en && in_start;
  assign shamt_sel_c = use_imm_q ? imm_q : in_rdata_2[SHAMT_W-1:0];

`ifdef SWITCH_MCU_ALU_SHIFT_SERIAL_EN
  function automatic logic [XLEN-1:0] shift_one(input logic [1:0] op, input logic [XLEN-1:0] a);
    case (op)
      OP_SLL:  shift_one = {a[XLEN-2:0], 1'b0};
      OP_SRA:  shift_one = {a[XLEN-1], a[XLEN-1:1]};
      default: shift_one = {1'b0, a[XLEN-1:1]};
    endcase
  endfunction

  // shamt_q doubles as the remaining-bits counter; operand_q holds the running result.
  assign shift_last_c = (shamt_q == '0);
  assign result_c     = operand_q;
`else
  function automatic logic [XLEN-1:0] shift_bar(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                input logic [SHAMT_W-1:0] s);
    case (op)
      OP_SLL:  shift_bar = a << s;
      OP_SRA:  shift_bar = $unsigned($signed(a) >>> s);
      default: shift_bar = a >> s;
    endcase
  endfunction

  assign shift_last_c = 1'b1;
  assign result_c     = shift_bar(op_q, operand_q, shamt_q);
`endif

  // State register
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_n   = state_q;
    ren_1_n   = 1'b0;
    ren_2_n   = 1'b0;
    raddr_1_n = '0;
    raddr_2_n = '0;
    wen_n     = 1'b0;
    waddr_n   = '0;
    wdata_n   = '0;
    done_n    = 1'b0;
    busy_n    = 1'b0;
    if (!in_en) begin
      state_n = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_start) begin
            state_n   = S_READ;
            ren_1_n   = 1'b1;
            raddr_1_n = in_rs1;
            if (!in_use_imm) begin
              ren_2_n   = 1'b1;
              raddr_2_n = in_rs2;
            end
          end
        end
        S_READ:    state_n = S_CAPTURE;
        S_CAPTURE: state_n = S_SHIFT;
        S_SHIFT: begin
          if (shift_last_c) begin
            state_n = S_WRITE;
            done_n  = 1'b1;
            if (rd_q != '0) begin
              wen_n   = 1'b1;
              waddr_n = rd_q;
              wdata_n = result_c;
            end
          end
        end
        S_WRITE:   state_n = S_IDLE;
        default:   state_n = S_IDLE;
      endcase
    end
    busy_n = (state_n != S_IDLE);
  end

  // Output registers
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      out_ren_1   <= 1'b0;
      out_ren_2   <= 1'b0;
      out_raddr_1 <= '0;
      out_raddr_2 <= '0;
      out_wen     <= 1'b0;
      out_waddr   <= '0;
      out_wdata   <= '0;
      out_busy    <= 1'b0;
      out_done    <= 1'b0;
    end else begin
      out_ren_1   <= ren_1_n;
      out_ren_2   <= ren_2_n;
      out_raddr_1 <= raddr_1_n;
      out_raddr_2 <= raddr_2_n;
      out_wen     <= wen_n;
      out_waddr   <= waddr_n;
      out_wdata   <= wdata_n;
      out_busy    <= busy_n;
      out_done    <= done_n;
    end
  end

  // Latched request fields and shift datapath
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      op_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      rd_q      <= '0;
      operand_q <= '0;
      shamt_q   <= '0;
    end else begin
      if (launch_c) begin
        op_q      <= in_op;
        use_imm_q <= in_use_imm;
        imm_q     <= in_imm_type_i[SHAMT_W-1:0];
        rd_q      <= in_rd;
      end
      if (state_q == S_CAPTURE && in_en) begin
        operand_q <= in_rdata_1;
        shamt_q   <= shamt_sel_c;
      end
`ifdef SWITCH_MCU_ALU_SHIFT_SERIAL_EN
      if (state_q == S_SHIFT && in_en && !shift_last_c) begin
        operand_q <= shift_one(op_q, operand_q);
        shamt_q   <= shamt_q - SHAMT_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_switch_mcu_alu_shift.sv
// Directed vector bench for switch_mcu_alu_shift with a one-cycle-latency register-file model.
module tb_switch_mcu_alu_shift;

  localparam int XLEN = 32;
  localparam int MAXC = 45;

  logic            in_clk = 1'b0;
  logic            in_rst = 1'b1;
  logic            in_en = 1'b0;
  logic            in_start = 1'b0;
  logic [1:0]      in_op = '0;
  logic            in_use_imm = 1'b0;
  logic [11:0]     in_imm_type_i = '0;
  logic [4:0]      in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [XLEN-1:0] in_rdata_1 = '0, in_rdata_2 = '0;
  logic            out_ren_1, out_ren_2, out_wen, out_busy, out_done;
  logic [4:0]      out_raddr_1, out_raddr_2, out_waddr;
  logic [XLEN-1:0] out_wdata;

  logic [XLEN-1:0] rf [32];
  int n_checks = 0;
  int n_errors = 0;

  switch_mcu_alu_shift #(.XLEN(32), .SHAMT_W(5)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_en(in_en), .in_start(in_start), .in_op(in_op),
    .in_use_imm(in_use_imm), .in_imm_type_i(in_imm_type_i), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_rdata_1(in_rdata_1), .in_rdata_2(in_rdata_2),
    .out_ren_1(out_ren_1), .out_ren_2(out_ren_2), .out_raddr_1(out_raddr_1),
    .out_raddr_2(out_raddr_2), .out_wen(out_wen), .out_waddr(out_waddr), .out_wdata(out_wdata),
    .out_busy(out_busy), .out_done(out_done)
  );

  always #5 in_clk = ~in_clk;

  // Register file: data appears the cycle after a read enable, junk otherwise
  always @(posedge in_clk) begin
    in_rdata_1 <= out_ren_1 ? rf[out_raddr_1] : 32'hDEAD_BEEF;
    in_rdata_2 <= out_ren_2 ? rf[out_raddr_2] : 32'hA5A5_A5A5;
  end

  typedef struct {
    logic [1:0]  op;
    logic        use_imm;
    logic [11:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, exp;
    int          shamt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [51:0] all_outs();
    return {out_ren_1, out_ren_2, out_raddr_1, out_raddr_2, out_wen, out_waddr, out_wdata,
            out_busy, out_done};
  endfunction

  function automatic int exp_lat(input int shamt);
`ifdef SWITCH_MCU_ALU_SHIFT_SERIAL_EN
    return 4 + shamt;
`else
    if (shamt < 0) return 0;
    return 4;
`endif
  endfunction

  task automatic launch(input vec_t v);
    rf[v.rs1] = v.d1;
    rf[v.rs2] = v.d2;
    @(negedge in_clk);
    in_op = v.op; in_use_imm = v.use_imm; in_imm_type_i = v.imm;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd; in_start = 1'b1;
    @(posedge in_clk); #1;
    in_start = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input int restart_cyc, input string tag);
    int done_cnt = 0, wen_cnt = 0, done_cyc = -1, wen_cyc = -1;
    logic [31:0] wdata_at = '0;
    logic [4:0]  waddr_at = '0;
    logic        ren1_c1 = 0, ren2_c1 = 0, busy_c1 = 0;
    logic [4:0]  ra1_c1 = '0, ra2_c1 = '0;
    launch(v);
    for (int cyc = 1; cyc <= MAXC; cyc++) begin
      if (cyc == 1) begin
        ren1_c1 = out_ren_1; ren2_c1 = out_ren_2; busy_c1 = out_busy;
        ra1_c1 = out_raddr_1; ra2_c1 = out_raddr_2;
      end
      if (out_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc; wdata_at = out_wdata; waddr_at = out_waddr;
        end
      end
      if (out_wen) begin
        wen_cnt++;
        if (wen_cyc < 0) wen_cyc = cyc;
      end
      in_start = (cyc == restart_cyc);
      @(posedge in_clk); #1;
    end
    in_start = 1'b0;
    chk({tag, " ren_1 in READ"}, 64'(ren1_c1), 64'd1);
    chk({tag, " raddr_1 in READ"}, 64'(ra1_c1), 64'(v.rs1));
    chk({tag, " ren_2 in READ"}, 64'(ren2_c1), 64'(!v.use_imm));
    chk({tag, " raddr_2 in READ"}, 64'(ra2_c1), v.use_imm ? 64'd0 : 64'(v.rs2));
    chk({tag, " busy in READ"}, 64'(busy_c1), 64'd1);
    chk({tag, " done cycle"}, 64'(done_cyc), 64'(exp_lat(v.shamt)));
    chk({tag, " done count"}, 64'(done_cnt), 64'd1);
    if (v.rd != 5'd0) begin
      chk({tag, " wen cycle"}, 64'(wen_cyc), 64'(exp_lat(v.shamt)));
      chk({tag, " wen count"}, 64'(wen_cnt), 64'd1);
      chk({tag, " waddr"}, 64'(waddr_at), 64'(v.rd));
      chk({tag, " wdata"}, 64'(wdata_at), 64'(v.exp));
    end else begin
      chk({tag, " wen count rd0"}, 64'(wen_cnt), 64'd0);
      chk({tag, " waddr rd0"}, 64'(waddr_at), 64'd0);
      chk({tag, " wdata rd0"}, 64'(wdata_at), 64'd0);
    end
    chk({tag, " idle after"}, 64'(out_busy), 64'd0);
  endtask

  initial begin
    int wcnt, dcnt;
    vecs[0] = '{2'b01, 1'b1, 12'h004, 5'd1, 5'd2, 5'd5, 32'h8000_0000, 32'h0, 32'h0800_0000, 4};
    vecs[1] = '{2'b10, 1'b1, 12'h004, 5'd1, 5'd2, 5'd5, 32'h8000_0000, 32'h0, 32'hF800_0000, 4};
    vecs[2] = '{2'b00, 1'b0, 12'h000, 5'd3, 5'd4, 5'd7, 32'h0000_0001, 32'h3F, 32'h8000_0000, 31};
    vecs[3] = '{2'b11, 1'b1, 12'hFE4, 5'd6, 5'd8, 5'd9, 32'hF000_0000, 32'h0, 32'h0F00_0000, 4};
    vecs[4] = '{2'b10, 1'b1, 12'h020, 5'd10, 5'd11, 5'd12, 32'h89AB_CDEF, 32'h0, 32'h89AB_CDEF, 0};
    vecs[5] = '{2'b00, 1'b1, 12'h001, 5'd13, 5'd14, 5'd0, 32'h0000_0005, 32'h0, 32'h0, 1};
    vecs[6] = '{2'b10, 1'b0, 12'h000, 5'd15, 5'd16, 5'd17, 32'h7FFF_FFFE, 32'hFFFF_FFE1, 32'h3FFF_FFFF, 1};
    vecs[7] = '{2'b01, 1'b1, 12'h007, 5'd18, 5'd19, 5'd20, 32'hFFFF_FFFF, 32'h0, 32'h01FF_FFFF, 7};
    vecs[8] = '{2'b10, 1'b1, 12'h01F, 5'd21, 5'd22, 5'd23, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 31};
    vecs[9] = '{2'b00, 1'b1, 12'h008, 5'd24, 5'd25, 5'd26, 32'h1234_5678, 32'h0, 32'h3456_7800, 8};
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;

    // Asynchronous reset with no clock edge involved
    #2 in_rst = 1'b0;
    #1 chk("reset outputs", 64'(all_outs()), 64'd0);
    @(negedge in_clk); in_rst = 1'b1;

    // Start while disabled is ignored
    in_start = 1'b1; in_en = 1'b0;
    @(posedge in_clk); #1;
    chk("start with en low busy", 64'(out_busy), 64'd0);
    chk("start with en low ren", 64'(out_ren_1), 64'd0);
    in_start = 1'b0; in_en = 1'b1;

    for (int i = 0; i < 10; i++) run_op(vecs[i], 0, $sformatf("vec%0d", i));

    // Second start during CAPTURE is ignored
    run_op(vecs[0], 2, "restart ignored");
    run_op(vecs[5], 2, "restart ignored rd0");

    // Enable dropped during SHIFT aborts the operation
    launch(vecs[9]);
    @(posedge in_clk); #1;
    @(posedge in_clk); #1;
    chk("abort busy in SHIFT", 64'(out_busy), 64'd1);
    in_en = 1'b0;
    @(posedge in_clk); #1;
    chk("abort outputs next cycle", 64'(all_outs()), 64'd0);
    in_en = 1'b1;
    wcnt = 0; dcnt = 0;
    for (int c = 0; c < MAXC; c++) begin
      if (out_wen) wcnt++;
      if (out_done) dcnt++;
      @(posedge in_clk); #1;
    end
    chk("abort no write", 64'(wcnt), 64'd0);
    chk("abort no done", 64'(dcnt), 64'd0);

    // Reset during CAPTURE clears outputs immediately, no write afterwards
    launch(vecs[7]);
    @(posedge in_clk); #1;
    chk("busy in CAPTURE", 64'(out_busy), 64'd1);
    in_rst = 1'b0;
    #1 chk("reset in CAPTURE outputs", 64'(all_outs()), 64'd0);
    @(negedge in_clk); in_rst = 1'b1;
    wcnt = 0; dcnt = 0;
    for (int c = 0; c < MAXC; c++) begin
      @(posedge in_clk); #1;
      if (out_wen) wcnt++;
      if (out_done || out_busy) dcnt++;
    end
    chk("reset no write", 64'(wcnt), 64'd0);
    chk("reset no activity", 64'(dcnt), 64'd0);

    // Unit still works after abort and reset
    run_op(vecs[1], 0, "post reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
